// File: rtl/freq_gate_counter.sv
// Gated-window frequency counter: counts clk_test edges per gate window and auto-ranges
// the result to Hz (integer) or kHz (one decimal) for the six-digit display stage.
module freq_gate_counter #(
  parameter int GATE_CNT_MAX = 49_999_999,
  parameter int CNT_W        = 25
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        clk_test,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        seg_en,
  output logic        over_range,
  output logic        meas_done
);

  localparam int               GW        = $clog2(GATE_CNT_MAX + 1);
  localparam int               DW        = $clog2(CNT_W + 1);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CNT_MAX);
  localparam logic [CNT_W-1:0] EDGE_MAX  = {CNT_W{1'b1}};
  localparam logic [7:0]       DIVISOR   = 8'd100;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DIV, S_UPDATE} state_t;
  state_t r_state, w_next;

  logic             r_s1, r_s2, r_s3;
  logic [GW-1:0]    r_cnt_gate;
  logic [CNT_W-1:0] r_cnt_edge, r_cnt_latch, r_quo;
  logic             r_sat, r_sat_latch, r_khz;
  logic [6:0]       r_rem;
  logic [DW-1:0]    r_div_cnt;

  logic w_edge, w_gate_end, w_edge_ovf, w_fits, w_ge;
  logic [7:0] w_trial, w_sub;

  assign w_edge     = r_s2 & ~r_s3;
  assign w_gate_end = (r_cnt_gate == GATE_LAST);
  assign w_edge_ovf = w_edge & (r_cnt_edge == EDGE_MAX);
  assign w_fits     = (32'(r_cnt_latch) <= 32'd999_999);
  // Restoring step: trial < 200, so bit 7 of (trial - 100) is set exactly when trial < 100.
  assign w_trial    = {r_rem, r_quo[CNT_W-1]};
  assign w_sub      = w_trial - DIVISOR;
  assign w_ge       = ~w_sub[7];
  assign sign       = 1'b0;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
      r_cnt_gate <= '0;
    end else begin
      r_s1 <= clk_test;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_cnt_gate <= w_gate_end ? '0 : r_cnt_gate + GW'(1);
    end
  end

  // An edge coinciding with gate_end is folded into the closing window's latch.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_edge  <= '0;
      r_sat       <= 1'b0;
      r_cnt_latch <= '0;
      r_sat_latch <= 1'b0;
    end else if (w_gate_end) begin
      r_cnt_latch <= w_edge_ovf ? r_cnt_edge : r_cnt_edge + CNT_W'(w_edge);
      r_sat_latch <= r_sat | w_edge_ovf;
      r_cnt_edge  <= '0;
      r_sat       <= 1'b0;
    end else if (w_edge) begin
      if (w_edge_ovf) r_sat <= 1'b1;
      else            r_cnt_edge <= r_cnt_edge + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_gate_end) w_next = S_CHECK;
      S_CHECK:  w_next = w_fits ? S_UPDATE : S_DIV;
      S_DIV:    if (r_div_cnt == '0) w_next = S_UPDATE;
      S_UPDATE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // r_quo carries the Hz count directly, or shifts in quotient bits MSB first in DIV.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_quo      <= '0;
      r_rem      <= '0;
      r_div_cnt  <= '0;
      r_khz      <= 1'b0;
      data       <= '0;
      point      <= '0;
      seg_en     <= 1'b0;
      over_range <= 1'b0;
      meas_done  <= 1'b0;
    end else begin
      meas_done <= (r_state == S_UPDATE);
      case (r_state)
        S_CHECK: begin
          r_quo     <= r_cnt_latch;
          r_rem     <= '0;
          r_div_cnt <= DW'(CNT_W - 1);
          r_khz     <= ~w_fits;
        end
        S_DIV: begin
          r_quo     <= {r_quo[CNT_W-2:0], w_ge};
          r_rem     <= w_ge ? w_sub[6:0] : w_trial[6:0];
          r_div_cnt <= r_div_cnt - DW'(1);
        end
        S_UPDATE: begin
          data       <= 20'(r_quo);
          point      <= r_khz ? 6'b000010 : 6'b000000;
          over_range <= r_sat_latch;
          seg_en     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
